// File: rtl/rename_pkg.sv
// rename_pkg: shared defaults and record types for the register-rename unit.
//   Default sizing: 32 architectural, 64 physical registers, 32-entry active
//   list, 4 branch checkpoints. The record types below are sized for the
//   default configuration; the rename unit re-derives its internal types
//   from its own parameters so that overrides stay consistent.
package rename_pkg;

    localparam int unsigned NUM_ARCH_REGS_DEF = 32;
    localparam int unsigned NUM_PHYS_REGS_DEF = 64;
    localparam int unsigned AL_DEPTH_DEF      = 32;
    localparam int unsigned NUM_CKPT_DEF      = 4;

    localparam int unsigned AW_DEF  = $clog2(NUM_ARCH_REGS_DEF);
    localparam int unsigned PW_DEF  = $clog2(NUM_PHYS_REGS_DEF);
    localparam int unsigned FLW_DEF = $clog2(NUM_PHYS_REGS_DEF - NUM_ARCH_REGS_DEF);
    localparam int unsigned ALW_DEF = $clog2(AL_DEPTH_DEF);

    typedef logic [PW_DEF-1:0] PhysReg_t;
    typedef logic [AW_DEF-1:0] ArchReg_t;

    typedef struct packed {
        ArchReg_t arch;
        PhysReg_t old_phys;
        PhysReg_t new_phys;
        logic     writes;
    } Al_Entry_t;

    typedef struct packed {
        PhysReg_t [NUM_ARCH_REGS_DEF-1:0] rmt;
        logic     [FLW_DEF:0]             fl_head;
        logic     [ALW_DEF:0]             al_tail;
    } Ckpt_t;

endpackage

// File: rtl/rename_ckpt_unit_fifo.sv
// free_list_fifo: circular FIFO with wrap-bit pointers and pointer restore.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write at tail
//   pop, head_data    : head entry (combinational) and advance head
//   set_head, head_in : overwrite head pointer (takes priority over pop)
//   set_tail, tail_in : overwrite tail pointer (takes priority over push)
//   head_ptr, tail_ptr: pointers including the wrap bit
//   full, empty       : occupancy flags
// With INIT_FULL set, reset fills entry i with INIT_BASE+i and marks the
// FIFO full (free-list use); otherwise reset leaves it empty.
module free_list_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 32,
    parameter bit          INIT_FULL = 1'b0,
    parameter int unsigned INIT_BASE = 0,
    localparam int unsigned IW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    input  logic             set_head,
    input  logic [IW:0]      head_in,
    input  logic             set_tail,
    input  logic [IW:0]      tail_in,
    output logic [IW:0]      head_ptr,
    output logic [IW:0]      tail_ptr,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= INIT_FULL ? {1'b1, {IW{1'b0}}} : '0;
            if (INIT_FULL) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[i] <= WIDTH'(INIT_BASE + i);
                end
            end
        end else begin
            if (push) begin
                mem[tail_ptr[IW-1:0]] <= push_data;
            end
            head_ptr <= set_head ? head_in : head_ptr + {{IW{1'b0}}, pop};
            tail_ptr <= set_tail ? tail_in : tail_ptr + {{IW{1'b0}}, push};
        end
    end

    assign head_data = mem[head_ptr[IW-1:0]];
    assign empty     = (head_ptr == tail_ptr);
    assign full      = (head_ptr[IW-1:0] == tail_ptr[IW-1:0]) && (head_ptr[IW] != tail_ptr[IW]);

endmodule

// File: rtl/rename_ckpt_unit.sv
// rename_ckpt_unit: register rename with branch checkpoints.
//   clk, rst                         : clock, synchronous active-high reset
//   ren_valid/ren_ready              : decode handshake
//   ren_rs, ren_rt, ren_rw           : architectural sources / destination
//   ren_uses_rw, ren_is_branch       : destination write, checkpoint request
//   out_valid, out_*_phys            : registered rename result (1 cycle)
//   out_rs_ready, out_rt_ready       : source operands not busy
//   out_ckpt_id                      : checkpoint tag of a renamed branch
//   wb_valid, wb_phys                : writeback clears a busy bit
//   cm_valid                         : commit oldest active-list entry
//   br_valid, br_id, br_mispredict   : oldest-first branch resolution
//   flush                            : squash to committed state
module rename_ckpt_unit
    import rename_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
    parameter int unsigned NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
    parameter int unsigned AL_DEPTH      = AL_DEPTH_DEF,
    parameter int unsigned NUM_CKPT      = NUM_CKPT_DEF,
    localparam int unsigned AW = $clog2(NUM_ARCH_REGS),
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS),
    localparam int unsigned CW = $clog2(NUM_CKPT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ren_valid,
    output logic          ren_ready,
    input  logic [AW-1:0] ren_rs,
    input  logic [AW-1:0] ren_rt,
    input  logic [AW-1:0] ren_rw,
    input  logic          ren_uses_rw,
    input  logic          ren_is_branch,
    output logic          out_valid,
    output logic [PW-1:0] out_rs_phys,
    output logic [PW-1:0] out_rt_phys,
    output logic [PW-1:0] out_rw_phys,
    output logic [PW-1:0] out_old_phys,
    output logic          out_rs_ready,
    output logic          out_rt_ready,
    output logic [CW-1:0] out_ckpt_id,
    input  logic          wb_valid,
    input  logic [PW-1:0] wb_phys,
    input  logic          cm_valid,
    input  logic          br_valid,
    input  logic [CW-1:0] br_id,
    input  logic          br_mispredict,
    input  logic          flush
);

    localparam int unsigned FD  = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned FLW = $clog2(FD);
    localparam int unsigned ALW = $clog2(AL_DEPTH);

    typedef logic [PW-1:0] phys_t;
    typedef struct packed {
        logic [AW-1:0] arch;
        phys_t         old_phys;
        phys_t         new_phys;
        logic          writes;
    } al_entry_t;

    phys_t rmt [NUM_ARCH_REGS];
    phys_t rmt_post [NUM_ARCH_REGS];
    phys_t amt [NUM_ARCH_REGS];
    phys_t amt_next [NUM_ARCH_REGS];
    phys_t ckpt_rmt [NUM_CKPT][NUM_ARCH_REGS];
    logic [FLW:0] ckpt_fl_head [NUM_CKPT];
    logic [ALW:0] ckpt_al_tail [NUM_CKPT];
    logic [CW:0]  ckpt_head, ckpt_tail;
    logic [NUM_PHYS_REGS-1:0] busy;

    logic [FLW:0] fl_head_ptr, fl_tail_ptr, fl_head_in;
    logic [ALW:0] al_head_ptr, al_tail_ptr, al_tail_in;
    phys_t        fl_head_data;
    logic         fl_full, fl_empty, al_full, al_empty;
    al_entry_t    al_head_entry, al_push_entry;

    logic uses_rw, mispredict, transfer, alloc, take_ckpt, ckpt_full, commit, commit_free, restore;

    assign uses_rw     = ren_uses_rw && (ren_rw != '0);
    assign mispredict  = br_valid && br_mispredict;
    assign restore     = flush || mispredict;
    assign ckpt_full   = (ckpt_head[CW-1:0] == ckpt_tail[CW-1:0]) && (ckpt_head[CW] != ckpt_tail[CW]);
    assign ren_ready   = !rst && !flush && !mispredict && !al_full
                         && (!uses_rw || !fl_empty) && (!ren_is_branch || !ckpt_full);
    assign transfer    = ren_valid && ren_ready;
    assign alloc       = transfer && uses_rw;
    assign take_ckpt   = transfer && ren_is_branch;
    assign commit      = cm_valid && !al_empty;
    assign commit_free = commit && al_head_entry.writes;

    assign al_push_entry = '{arch: ren_rw, old_phys: rmt[ren_rw], new_phys: fl_head_data, writes: uses_rw};

    // The free list keeps exactly FD slots in flight, so the committed free
    // set is always the FD entries just behind the (post-commit) tail.
    assign fl_head_in = flush ? fl_tail_ptr + (FLW+1)'(commit_free) - (FLW+1)'(FD)
                              : ckpt_fl_head[br_id];
    assign al_tail_in = flush ? al_head_ptr + (ALW+1)'(commit) : ckpt_al_tail[br_id];

    free_list_fifo #(.WIDTH(PW), .DEPTH(FD), .INIT_FULL(1'b1), .INIT_BASE(NUM_ARCH_REGS)) fl_fifo (
        .clk(clk), .rst(rst),
        .push(commit_free), .push_data(al_head_entry.old_phys),
        .pop(alloc), .head_data(fl_head_data),
        .set_head(restore), .head_in(fl_head_in),
        .set_tail(1'b0), .tail_in('0),
        .head_ptr(fl_head_ptr), .tail_ptr(fl_tail_ptr),
        .full(fl_full), .empty(fl_empty)
    );

    free_list_fifo #(.WIDTH($bits(al_entry_t)), .DEPTH(AL_DEPTH), .INIT_FULL(1'b0), .INIT_BASE(0)) al_fifo (
        .clk(clk), .rst(rst),
        .push(transfer), .push_data(al_push_entry),
        .pop(commit), .head_data(al_head_entry),
        .set_head(1'b0), .head_in('0),
        .set_tail(restore), .tail_in(al_tail_in),
        .head_ptr(al_head_ptr), .tail_ptr(al_tail_ptr),
        .full(al_full), .empty(al_empty)
    );

    always_comb begin
        rmt_post = rmt;
        if (alloc) rmt_post[ren_rw] = fl_head_data;
        amt_next = amt;
        if (commit_free) amt_next[al_head_entry.arch] = al_head_entry.new_phys;
    end

    function automatic logic src_ready(input phys_t p);
        return !busy[p] || (wb_valid && (wb_phys == p));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
                rmt[i] <= PW'(i);
                amt[i] <= PW'(i);
            end
            busy      <= '0;
            ckpt_head <= '0;
            ckpt_tail <= '0;
            out_valid <= 1'b0;
        end else begin
            amt <= amt_next;
            if (flush)           rmt <= amt_next;
            else if (mispredict) rmt <= ckpt_rmt[br_id];
            else                 rmt <= rmt_post;

            if (flush) begin
                busy <= '0;
            end else begin
                if (wb_valid) busy[wb_phys] <= 1'b0;
                if (alloc)    busy[fl_head_data] <= 1'b1;
            end

            // Resolution is always of the oldest checkpoint, so a mispredict
            // empties the checkpoint queue entirely.
            if (flush) begin
                ckpt_tail <= ckpt_head;
            end else if (br_valid) begin
                ckpt_head <= ckpt_head + (CW+1)'(1);
                if (mispredict) ckpt_tail <= ckpt_head + (CW+1)'(1);
            end
            if (take_ckpt) begin
                ckpt_tail                        <= ckpt_tail + (CW+1)'(1);
                ckpt_rmt[ckpt_tail[CW-1:0]]      <= rmt_post;
                ckpt_fl_head[ckpt_tail[CW-1:0]]  <= fl_head_ptr + (FLW+1)'(alloc);
                ckpt_al_tail[ckpt_tail[CW-1:0]]  <= al_tail_ptr + (ALW+1)'(1);
            end

            out_valid <= transfer;
            if (transfer) begin
                out_rs_phys  <= rmt[ren_rs];
                out_rt_phys  <= rmt[ren_rt];
                out_rw_phys  <= uses_rw ? fl_head_data : rmt[ren_rw];
                out_old_phys <= rmt[ren_rw];
                out_rs_ready <= src_ready(rmt[ren_rs]);
                out_rt_ready <= src_ready(rmt[ren_rt]);
                out_ckpt_id  <= ren_is_branch ? ckpt_tail[CW-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && br_valid && !flush) assert (br_id == ckpt_head[CW-1:0]);
        if (!rst) assert (!(commit_free && fl_full));
    end

endmodule

// File: tb/tb_rename_ckpt_unit.sv
module tb_rename_ckpt_unit;
    import rename_pkg::*;

    localparam int A   = NUM_ARCH_REGS_DEF;
    localparam int P   = NUM_PHYS_REGS_DEF;
    localparam int ALD = AL_DEPTH_DEF;
    localparam int NC  = NUM_CKPT_DEF;
    localparam int AW  = $clog2(A);
    localparam int PW  = $clog2(P);
    localparam int CW  = $clog2(NC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ren_valid = 1'b0, ren_ready;
    logic [AW-1:0] ren_rs = '0, ren_rt = '0, ren_rw = '0;
    logic ren_uses_rw = 1'b0, ren_is_branch = 1'b0;
    logic out_valid;
    logic [PW-1:0] out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys;
    logic out_rs_ready, out_rt_ready;
    logic [CW-1:0] out_ckpt_id;
    logic wb_valid = 1'b0;
    logic [PW-1:0] wb_phys = '0;
    logic cm_valid = 1'b0, br_valid = 1'b0, br_mispredict = 1'b0, flush = 1'b0;
    logic [CW-1:0] br_id = '0;

    always #5 clk = ~clk;

    rename_ckpt_unit #(.NUM_ARCH_REGS(A), .NUM_PHYS_REGS(P), .AL_DEPTH(ALD), .NUM_CKPT(NC)) dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ren_ready(ren_ready),
        .ren_rs(ren_rs), .ren_rt(ren_rt), .ren_rw(ren_rw),
        .ren_uses_rw(ren_uses_rw), .ren_is_branch(ren_is_branch),
        .out_valid(out_valid), .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys),
        .out_rw_phys(out_rw_phys), .out_old_phys(out_old_phys),
        .out_rs_ready(out_rs_ready), .out_rt_ready(out_rt_ready), .out_ckpt_id(out_ckpt_id),
        .wb_valid(wb_valid), .wb_phys(wb_phys), .cm_valid(cm_valid),
        .br_valid(br_valid), .br_id(br_id), .br_mispredict(br_mispredict), .flush(flush)
    );

    // ---------------- reference model ----------------
    typedef struct { int rs; int rt; int rw; int old; bit writes; bit rs_rdy; bit rt_rdy; bit br; int ckid; } exp_t;
    typedef struct { int seq; int arch; int old; int newp; bit writes; } al_t;
    typedef struct { int id; int seq; } ck_t;

    exp_t sb[$];
    al_t  al_q[$];
    ck_t  ck_q[$];
    int   free_q[$];
    int   m_rmt[A];
    int   m_amt[A];
    int   ck_rmt[NC][A];
    bit   m_busy[P];
    int   head_id;
    int   seq_ctr;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < A; i++) begin
            m_rmt[i] = i;
            m_amt[i] = i;
        end
        for (int i = 0; i < P; i++) m_busy[i] = 1'b0;
        free_q.delete();
        for (int i = A; i < P; i++) free_q.push_back(i);
        al_q.delete();
        ck_q.delete();
        sb.delete();
        head_id = 0;
        seq_ctr = 0;
    endfunction

    // Undo every in-flight instruction younger than seq; their registers
    // go back to the front of the free list in allocation order.
    function automatic void squash_after(input int seq);
        al_t t;
        while (al_q.size() > 0 && al_q[al_q.size()-1].seq > seq) begin
            t = al_q.pop_back();
            if (t.writes) free_q.push_front(t.newp);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ren_valid = 1'b0; cm_valid = 1'b0; wb_valid = 1'b0;
        br_valid = 1'b0; br_mispredict = 1'b0; flush = 1'b0;
        #1;
        chk("ren_ready_in_rst", ren_ready, 0);
        model_reset();
    endtask

    task automatic step(input bit v, input int rs, input int rt, input int rw, input bit uses, input bit br,
                        input bit wbv, input int wbp, input bit cm,
                        input bit bv, input int bid, input bit bmis, input bit fl);
        exp_t e;
        al_t  a;
        al_t  c;
        ck_t  k;
        bit   uses_eff, mis, exp_rdy, xfer;
        @(negedge clk);
        rst = 1'b0;
        ren_valid = v; ren_rs = rs[AW-1:0]; ren_rt = rt[AW-1:0]; ren_rw = rw[AW-1:0];
        ren_uses_rw = uses; ren_is_branch = br;
        wb_valid = wbv; wb_phys = wbp[PW-1:0]; cm_valid = cm;
        br_valid = bv; br_id = bid[CW-1:0]; br_mispredict = bmis; flush = fl;
        #1;
        uses_eff = uses && (rw != 0);
        mis      = bv && bmis;
        exp_rdy  = !fl && !mis && (al_q.size() < ALD) && (!uses_eff || free_q.size() > 0)
                   && (!br || ck_q.size() < NC);
        chk("ren_ready", ren_ready, exp_rdy);
        xfer = v && exp_rdy;

        if (xfer) begin
            e.rs     = m_rmt[rs];
            e.rt     = m_rmt[rt];
            e.rs_rdy = !m_busy[e.rs] || (wbv && wbp == e.rs);
            e.rt_rdy = !m_busy[e.rt] || (wbv && wbp == e.rt);
            e.old    = m_rmt[rw];
            e.writes = uses_eff;
            e.br     = br;
            e.ckid   = (head_id + ck_q.size()) % NC;
            e.rw     = 0;
            if (uses_eff) begin
                e.rw = free_q.pop_front();
                m_rmt[rw] = e.rw;
            end
            seq_ctr++;
            a.seq = seq_ctr; a.arch = rw; a.old = e.old; a.newp = e.rw; a.writes = uses_eff;
            al_q.push_back(a);
            if (br) begin
                k.id = e.ckid; k.seq = seq_ctr;
                ck_q.push_back(k);
                ck_rmt[e.ckid] = m_rmt;
            end
            sb.push_back(e);
        end

        if (cm && al_q.size() > 0) begin
            c = al_q.pop_front();
            if (c.writes) begin
                m_amt[c.arch] = c.newp;
                free_q.push_back(c.old);
            end
        end

        if (wbv) m_busy[wbp] = 1'b0;
        if (xfer && uses_eff) m_busy[e.rw] = 1'b1;

        if (fl) begin
            m_rmt = m_amt;
            squash_after(-1);
            ck_q.delete();
            for (int i = 0; i < P; i++) m_busy[i] = 1'b0;
        end else if (bv && ck_q.size() > 0) begin
            k = ck_q.pop_front();
            head_id = (k.id + 1) % NC;
            if (bmis) begin
                m_rmt = ck_rmt[k.id];
                squash_after(k.seq);
                ck_q.delete();
            end
        end
    endtask

    // rename only, nothing else in the cycle
    task automatic ren(input int rs, input int rt, input int rw, input bit uses, input bit br);
        step(1, rs, rt, rw, uses, br, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("out_valid", out_valid, sb.size() != 0);
            if (out_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                chk("rs_phys", out_rs_phys, e.rs);
                chk("rt_phys", out_rt_phys, e.rt);
                chk("rs_ready", out_rs_ready, e.rs_rdy);
                chk("rt_ready", out_rt_ready, e.rt_rdy);
                if (e.writes) begin
                    chk("rw_phys", out_rw_phys, e.rw);
                    chk("old_phys", out_old_phys, e.old);
                end
                if (e.br) chk("ckpt_id", out_ckpt_id, e.ckid);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit cm_ok, bv, bmis, fl, wbv;
        int bid;

        // basic rename, back-to-back forwarding of mappings, writeback bypass
        do_reset();
        ren(1, 2, 3, 1, 0);
        ren(3, 0, 4, 1, 0);
        step(1, 4, 0, 5, 1, 0, 1, 32, 0, 0, 0, 0, 0);
        ren(3, 3, 6, 1, 0);
        ren(0, 0, 0, 1, 0);                       // write to r0 allocates nothing
        // exhaust the free list, then a commit frees phys 3 one cycle later
        for (int i = 0; i < 32; i++) ren(7, 8, 7, 1, 0);
        step(1, 1, 1, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        ren(1, 1, 9, 1, 0);
        ren(1, 1, 10, 1, 0);

        // commit together with flush
        do_reset();
        ren(1, 2, 3, 1, 0);
        ren(3, 3, 11, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        ren(3, 11, 12, 1, 0);
        for (int i = 0; i < 33; i++) ren(3, 12, 13, 1, 0);

        // checkpoint then mispredict
        do_reset();
        ren(1, 2, 0, 0, 1);
        ren(3, 3, 3, 1, 0);
        ren(3, 3, 3, 1, 0);
        ren(3, 3, 3, 1, 0);
        step(1, 3, 3, 3, 1, 0, 0, 0, 0, 1, ck_q[0].id, 1, 0);
        ren(3, 3, 3, 1, 0);

        // checkpoint exhaustion and tag wrap
        do_reset();
        for (int i = 0; i < 4; i++) ren(i, i, 0, 0, 1);
        ren(1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, ck_q[0].id, 0, 0);
        ren(1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ck_q[0].id, 0, 0);

        // randomised traffic
        do_reset();
        for (int unsigned n = 0; n < 4000; n++) begin
            cm_ok = al_q.size() > 0 && (ck_q.size() == 0 || al_q[0].seq <= ck_q[0].seq);
            bv    = ck_q.size() > 0 && $urandom_range(0, 3) == 0;
            bid   = ck_q.size() > 0 ? ck_q[0].id : 0;
            bmis  = $urandom_range(0, 2) == 0;
            fl    = $urandom_range(0, 199) == 0;
            wbv   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 4) != 0, $urandom_range(0, A-1), $urandom_range(0, A-1),
                     $urandom_range(0, A-1), $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0,
                     wbv, $urandom_range(0, P-1), cm_ok && $urandom_range(0, 1) == 1,
                     bv && !fl, bid, bmis, fl);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_ckpt_unit.md
# rename_ckpt_unit

Parametrised register-rename unit sitting between decode and the instruction queue. Maps architectural to physical registers through a rename map table (RMT), allocates from a free list, records old mappings in an in-order active list, and tracks per-physical-register busy bits. Adds multi-entry branch checkpoints with single-cycle mispredict recovery, commit-driven register reclamation, and full flush to the committed map.

## Interface
- NUM_ARCH_REGS, 32, architectural registers (A)
- NUM_PHYS_REGS, 64, physical registers (P); must be greater than A
- AL_DEPTH, 32, active-list entries (power of 2)
- NUM_CKPT, 4, branch checkpoints (power of 2)
- AW = $clog2(A), PW = $clog2(P), CW = $clog2(NUM_CKPT) (derived localparams)
- clk  in  1  clock
- rst  in  1  reset: one clock, synchronous, active-high
- ren_valid  in  1  decode presents an instruction
- ren_ready  out  1  unit can accept; transfer = ren_valid & ren_ready
- ren_rs, ren_rt, ren_rw  in  AW each  architectural sources and destination
- ren_uses_rw  in  1  instruction writes ren_rw (writes to r0 are treated as uses_rw=0)
- ren_is_branch  in  1  instruction takes a checkpoint
- out_valid  out  1  renamed result valid, one cycle after transfer
- out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys  out  PW each
- out_rs_ready, out_rt_ready  out  1 each  source not busy
- out_ckpt_id  out  CW  checkpoint tag (branches only)
- wb_valid  in  1, wb_phys  in  PW  writeback clears a busy bit
- cm_valid  in  1  commit the oldest active-list entry
- br_valid  in  1, br_id  in  CW, br_mispredict  in  1  branch resolution, oldest-first
- flush  in  1  full squash to the committed state

## Operation
- Reset: RMT[i]=i and AMT[i]=i; free list holds P-A..., physical ids A..P-1 in ascending order; active list empty; no checkpoints; all busy bits 0; out_valid=0; ren_ready=0 during rst and 1 in the first cycle after reset.
- ren_ready = !rst & !flush & !(br_valid & br_mispredict) & !al_full & (!ren_uses_rw | !fl_empty) & (!ren_is_branch | !ckpt_full).
- Rename on transfer:
  - Sources read the RMT before this instruction's own update. For example, rw=rs yields the old mapping.
  - If uses_rw: pop the free-list head to new_phys, set RMT[rw]=new_phys and busy[new_phys]=1. Push {rw, old=RMT[rw], new_phys} to the active list.
  - If !uses_rw: push an entry with a no-write flag.
- Source ready = !busy[p] | (wb_valid & wb_phys==p), a same-cycle writeback bypass.
- Checkpoint: a branch snapshots the post-rename RMT, the free-list head, and the active-list tail into slot ckpt_tail, then ckpt_tail++.
- Branch resolution:
  - br_id must equal ckpt_head; any other value is an assertion error.
  - Correct prediction: ckpt_head++.
  - Mispredict: restore RMT, free-list head and active-list tail from slot br_id, and discard all younger checkpoints (ckpt_tail = br_id+1, then pop the slot itself).
  - Busy bits are not restored; reallocation sets them again.
- Commit: pop the active-list head. If it writes, push old_phys to the free-list tail and set AMT[arch]=new_phys.
- Flush: RMT=AMT; free-list head = tail − (P−A); active list empty; checkpoints empty; all busy bits 0.
- Priority:
  - flush > mispredict > rename.
  - Commit and writeback always proceed in the same cycle, including under mispredict or flush.
  - Under flush, the same-cycle commit updates the AMT first, and the RMT copy uses the updated AMT.
- All FIFO pointers carry one extra wrap bit. Full = same index with a differing wrap bit; count = tail−head modulo 2·depth.

## Timing
- Rename latency 1: outputs are registered on the transfer edge, and out_valid deasserts the cycle after a non-transfer.
- Back-to-back renames see the previous mapping. An instruction renamed in cycle n+1 sees the RMT update from cycle n.
- Recovery completes in the mispredict cycle. ren_ready is low in that cycle and high again in the next.
- A register freed by commit in cycle n is allocatable in cycle n+1; there is no same-cycle free-to-allocate bypass.
- rst mid-operation discards everything and returns to the reset state on the next edge.

## Structure
- rename_pkg: PhysReg_t, ArchReg_t, Al_Entry_t {arch, old_phys, new_phys, writes}, and Ckpt_t {rmt[A], fl_head, al_tail}.
- Sub-module free_list_fifo (parametrised width/depth): push, pop, head restore, full, empty. Instantiated for the free list; the active list is a second instance with an Al_Entry_t payload.

## Test plan
- Reset then rename add r3←r1,r2 -> rs_phys=1, rt_phys=2, rw_phys=32, old_phys=3, busy[32]=1, both sources ready.
- Rename r4←r3, then r5←r4, back-to-back -> rs_phys 32 then 33; wb_phys=32 in the second rename's cycle -> out_rs_ready=1 on the following rename reading 32.
- Allocate all 32 free registers with no commits -> ren_ready=0 for uses_rw while fl_empty; a commit frees old phys 3 -> ready next cycle, allocated id is 3.
- Branch (id 0), rename r3 three times, mispredict id 0 -> RMT[3] back to the snapshot value; next rename gets the same phys as the first squashed one.
- Four unresolved branches -> fifth stalls; resolve id 0 correct -> fifth accepted with ckpt_id 0 (wrap).
- Commit r3→32 together with flush -> RMT[3]=32, active list empty, all busy 0, free-list count = 32.
